// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// opcodes, FSM states, trap causes, write-back selects and access-width helpers.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Low two funct3 bits give the access width for both loads and stores.
    localparam logic [1:0] F3_BYTE = 2'b00;
    localparam logic [1:0] F3_HALF = 2'b01;
    localparam logic [1:0] F3_WORD = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic ls_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3[1:0])
            F3_HALF: bad = a[0];
            F3_WORD: bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] we;
        case (f3)
            3'b000:  we = 4'b0001 << a;
            3'b001:  we = 4'b0011 << {a[1], 1'b0};
            3'b010:  we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Branch (B-type) and jump (J-type) immediate extraction from the latched
// instruction, sign-extended to 32 bits.
module rv_imm_gen (
    input  logic [31:0] ir,
    output logic [31:0] imm_b,
    output logic [31:0] imm_j
);

    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: owns PC/IR, steps FETCH..WB, runs the
// imem/dmem request handshakes and halts with a sticky trap on faults.
module rv_mc_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          TO_W        = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    input  logic [31:0] alu_result,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t           state_r, state_s;
    logic [31:0]      pc_r, pc_s;
    logic [31:0]      ir_r, ir_s;
    logic [31:0]      addr_r, addr_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
    logic             trap_r, trap_s;
    logic [1:0]       cause_r, cause_s;

    logic             imem_req_s, dmem_req_s, rf_we_s, retire_s;
    logic [3:0]       dmem_we_s;
    logic [1:0]       wb_sel_s;
    logic [31:0]      imm_b_s, imm_j_s, pc_plus4_s, br_tgt_s, jmp_tgt_s;
    logic [TO_W-1:0]  to_next_s;
    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;

    rv_imm_gen u_imm_gen (
        .ir    (ir_r),
        .imm_b (imm_b_s),
        .imm_j (imm_j_s)
    );

    assign opcode_s   = ir_r[6:0];
    assign funct3_s   = ir_r[14:12];
    assign pc_plus4_s = pc_r + 32'd4;
    assign br_tgt_s   = pc_r + imm_b_s;
    assign to_next_s  = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        addr_s     = addr_r;
        to_cnt_s   = {TO_W{1'b0}};
        trap_s     = trap_r;
        cause_s    = cause_r;
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 4'b0000;
        rf_we_s    = 1'b0;
        retire_s   = 1'b0;
        jmp_tgt_s  = (opcode_s == OP_JALR) ? {alu_result[31:1], 1'b0} : (pc_r + imm_j_s);

        case (opcode_s)
            OP_LOAD:         wb_sel_s = WB_MEM;
            OP_JAL, OP_JALR: wb_sel_s = WB_PC4;
            default:         wb_sel_s = WB_ALU;
        endcase

        case (state_r)
            S_IDLE: begin
                state_s = S_FETCH;
            end
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_s    = imem_rdata;
                    state_s = S_DECODE;
                end else if (to_next_s == TO_LIMIT) begin
                    state_s = S_HALT;
                    trap_s  = 1'b1;
                    cause_s = CAUSE_TIMEOUT;
                end else begin
                    to_cnt_s = to_next_s;
                end
            end
            S_DECODE: begin
                if (is_legal_op(opcode_s)) begin
                    state_s = S_EXEC;
                end else begin
                    state_s = S_HALT;
                    trap_s  = 1'b1;
                    cause_s = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                addr_s = alu_result;
                if (opcode_s == OP_BRANCH) begin
                    if (br_taken && (br_tgt_s[1:0] != 2'b00)) begin
                        state_s = S_HALT;
                        trap_s  = 1'b1;
                        cause_s = CAUSE_MISALIGN;
                    end else begin
                        pc_s     = br_taken ? br_tgt_s : pc_plus4_s;
                        retire_s = 1'b1;
                        state_s  = S_FETCH;
                    end
                end else if ((opcode_s == OP_LOAD) || (opcode_s == OP_STORE)) begin
                    if (ls_misaligned(funct3_s, alu_result[1:0])) begin
                        state_s = S_HALT;
                        trap_s  = 1'b1;
                        cause_s = CAUSE_MISALIGN;
                    end else begin
                        state_s = S_MEM;
                    end
                end else begin
                    state_s = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (opcode_s == OP_STORE) ? store_strobe(funct3_s, addr_r[1:0]) : 4'b0000;
                if (dmem_ready) begin
                    if (opcode_s == OP_STORE) begin
                        pc_s     = pc_plus4_s;
                        retire_s = 1'b1;
                        state_s  = S_FETCH;
                    end else begin
                        state_s = S_WB;
                    end
                end else if (to_next_s == TO_LIMIT) begin
                    state_s = S_HALT;
                    trap_s  = 1'b1;
                    cause_s = CAUSE_TIMEOUT;
                end else begin
                    to_cnt_s = to_next_s;
                end
            end
            S_WB: begin
                if ((opcode_s == OP_JAL) || (opcode_s == OP_JALR)) begin
                    if (jmp_tgt_s[1:0] != 2'b00) begin
                        state_s = S_HALT;
                        trap_s  = 1'b1;
                        cause_s = CAUSE_MISALIGN;
                    end else begin
                        pc_s     = jmp_tgt_s;
                        rf_we_s  = (ir_r[11:7] != 5'd0);
                        retire_s = 1'b1;
                        state_s  = S_FETCH;
                    end
                end else begin
                    pc_s     = pc_plus4_s;
                    rf_we_s  = (ir_r[11:7] != 5'd0);
                    retire_s = 1'b1;
                    state_s  = S_FETCH;
                end
            end
            S_HALT: begin
                state_s = S_HALT;
            end
            default: begin
                state_s = S_HALT;
                trap_s  = 1'b1;
            end
        endcase
    end

    // Architectural state and fault registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            pc_r     <= RESET_PC;
            ir_r     <= 32'h0000_0000;
            addr_r   <= 32'h0000_0000;
            to_cnt_r <= {TO_W{1'b0}};
            trap_r   <= 1'b0;
            cause_r  <= 2'd0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            ir_r     <= ir_s;
            addr_r   <= addr_s;
            to_cnt_r <= to_cnt_s;
            trap_r   <= trap_s;
            cause_r  <= cause_s;
        end
    end

    assign imem_req   = imem_req_s;
    assign dmem_req   = dmem_req_s;
    assign dmem_we    = dmem_we_s;
    assign rf_we      = rf_we_s;
    assign retire     = retire_s;
    assign wb_sel     = wb_sel_s;
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign trap       = trap_r;
    assign trap_cause = cause_r;
    assign state      = state_r;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed, table-driven bench for rv_mc_ctrl: instruction sequence with
// hand-computed latency/PC/strobe expectations plus trap and reset corners.
module tb_rv_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_ready;
    logic [31:0] imem_rdata, pc, ir, alu_result;
    logic        br_taken, dmem_req, dmem_ready, rf_we, retire, trap;
    logic [3:0]  dmem_we;
    logic [1:0]  wb_sel, trap_cause;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_mc_ctrl #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .ir(ir), .alu_result(alu_result), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic        br;
        int          wait_n;
        int          cycles;
        logic        rf;
        logic [1:0]  wb;
        logic [3:0]  we;
        int          mem_n;
        logic [31:0] pc_after;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a negedge with the DUT in FETCH.
    task automatic do_reset();
        reset_n    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        alu_result = 32'h0;
        br_taken   = 1'b0;
        dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
        check("rst_strobes", {26'd0, imem_req, dmem_req, dmem_we}, 32'd0);
        check("rst_pulses", {30'd0, rf_we, retire}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("fetch_after_idle", {28'd0, imem_req, state}, {28'd0, 1'b1, 3'd1});
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   got_cyc = 0;
        int   mem_n   = 0;
        logic rf_seen = 1'b0;
        logic we_ok   = 1'b1;
        logic [1:0] wb_got = 2'd3;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            imem_ready = 1'b1;
            imem_rdata = v.instr;
            alu_result = v.alu;
            br_taken   = v.br;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) begin
                dmem_ready = (mem_n == v.wait_n);
                mem_n++;
                if (dmem_we !== v.we) we_ok = 1'b0;
            end
            #1;
            if (rf_we) rf_seen = 1'b1;
            if (retire) begin
                got_cyc = cyc;
                wb_got  = wb_sel;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check($sformatf("v%0d_cycles", idx), got_cyc, v.cycles);
        check($sformatf("v%0d_rf_we", idx), {31'd0, rf_seen}, {31'd0, v.rf});
        check($sformatf("v%0d_wb_sel", idx), {30'd0, wb_got}, {30'd0, v.wb});
        check($sformatf("v%0d_mem_cycles", idx), mem_n, v.mem_n);
        check($sformatf("v%0d_dmem_we_ok", idx), {31'd0, we_ok}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check($sformatf("v%0d_pc", idx), pc, v.pc_after);
        check($sformatf("v%0d_back_to_fetch", idx), {28'd0, trap, state}, {28'd0, 1'b0, 3'd1});
    endtask

    // Runs from FETCH until HALT (bounded) and checks the trap outcome.
    task automatic expect_halt(input string name, input logic [31:0] instr, input logic [31:0] alu,
                               input logic rdy, input logic [1:0] cause, input logic [31:0] exp_pc,
                               input int exp_req);
        int   req_n = 0;
        logic ret_seen = 1'b0;
        logic rf_seen  = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            imem_ready = rdy;
            imem_rdata = instr;
            alu_result = alu;
            br_taken   = 1'b0;
            dmem_ready = 1'b1;
            #1;
            if (imem_req) req_n++;
            if (retire) ret_seen = 1'b1;
            if (rf_we) rf_seen = 1'b1;
            if (state == 3'd6) break;
            @(posedge clk);
            @(negedge clk);
        end
        check({name, "_state"}, 32'(state), 32'd6);
        check({name, "_trap"}, {31'd0, trap}, 32'd1);
        check({name, "_cause"}, {30'd0, trap_cause}, {30'd0, cause});
        check({name, "_pc"}, pc, exp_pc);
        check({name, "_no_retire_rf"}, {30'd0, ret_seen, rf_seen}, 32'd0);
        check({name, "_reqs_low"}, {30'd0, imem_req, dmem_req}, 32'd0);
        if (exp_req >= 0) check({name, "_req_cycles"}, req_n, exp_req);
    endtask

    initial begin
        int   hold_bad;
        logic saw_dreq;

        vecs[0]  = '{32'h00500093, 32'd5,        1'b0, 0, 4, 1'b1, 2'd0, 4'h0, 0, 32'h0000_0004};
        vecs[1]  = '{32'h12345137, 32'h12345000, 1'b0, 0, 4, 1'b1, 2'd0, 4'h0, 0, 32'h0000_0008};
        vecs[2]  = '{32'h00208033, 32'd7,        1'b0, 0, 4, 1'b0, 2'd0, 4'h0, 0, 32'h0000_000C};
        vecs[3]  = '{32'h004000EF, 32'd0,        1'b0, 0, 4, 1'b1, 2'd2, 4'h0, 0, 32'h0000_0010};
        vecs[4]  = '{32'h00000463, 32'd0,        1'b1, 0, 3, 1'b0, 2'd0, 4'h0, 0, 32'h0000_0018};
        vecs[5]  = '{32'h00000463, 32'd0,        1'b0, 0, 3, 1'b0, 2'd0, 4'h0, 0, 32'h0000_001C};
        vecs[6]  = '{32'h00002023, 32'h200,      1'b0, 0, 4, 1'b0, 2'd0, 4'hF, 1, 32'h0000_0020};
        vecs[7]  = '{32'h00002183, 32'h204,      1'b0, 0, 5, 1'b1, 2'd1, 4'h0, 1, 32'h0000_0024};
        vecs[8]  = '{32'h00001023, 32'h106,      1'b0, 0, 4, 1'b0, 2'd0, 4'hC, 1, 32'h0000_0028};
        vecs[9]  = '{32'h000002E7, 32'h101,      1'b0, 0, 4, 1'b1, 2'd2, 4'h0, 0, 32'h0000_0100};
        vecs[10] = '{32'h00000217, 32'h100,      1'b0, 0, 4, 1'b1, 2'd0, 4'h0, 0, 32'h0000_0104};
        vecs[11] = '{32'hFE001EE3, 32'd0,        1'b1, 0, 3, 1'b0, 2'd0, 4'h0, 0, 32'h0000_0100};
        vecs[12] = '{32'h00000067, 32'hFFFFFFFD, 1'b0, 0, 4, 1'b0, 2'd2, 4'h0, 0, 32'hFFFF_FFFC};
        vecs[13] = '{32'h00500093, 32'd5,        1'b0, 0, 4, 1'b1, 2'd0, 4'h0, 0, 32'h0000_0000};
        vecs[14] = '{32'h00000023, 32'h103,      1'b0, 2, 6, 1'b0, 2'd0, 4'h8, 3, 32'h0000_0004};

        do_reset();
        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        expect_halt("lw_misalign", 32'h00002183, 32'h102, 1'b1, 2'd1, 32'h4, -1);

        do_reset();
        expect_halt("jal_misalign", 32'h002000EF, 32'h0, 1'b1, 2'd1, 32'h0, -1);

        do_reset();
        expect_halt("illegal", 32'h0000007F, 32'h0, 1'b1, 2'd0, 32'h0, -1);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if ((state != 3'd6) || retire || imem_req || !trap) hold_bad++;
        end
        check("halt_hold_20", hold_bad, 0);

        do_reset();
        expect_halt("fetch_timeout", 32'h00500093, 32'h0, 1'b0, 2'd2, 32'h0, 16);

        do_reset();
        saw_dreq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'b1;
            imem_rdata = 32'h00002183;
            alu_result = 32'h200;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) begin
                saw_dreq = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_mem_req_seen", {31'd0, saw_dreq}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_mem_reset_drop", {28'd0, dmem_req, state}, 32'd0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
Multi-cycle control sequencer for the RV32I integer datapath: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM/WB, and drives instruction-memory and data-memory request/ready handshakes.
Feeds IR to the instruction decoder; produces register-file write enable, write-back select, byte strobes and PC update.
Traps and halts on illegal opcode, misalignment or memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 16, max wait cycles for ready per request before timeout trap (≥2)
TO_W, 5, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction fetch request, address = pc
imem_ready  input  1  fetch complete this cycle; imem_rdata valid
imem_rdata  input  32  fetched instruction
pc  output  32  current program counter
ir  output  32  latched instruction, to decoder
alu_result  input  32  ALU output (EXEC): branch compare unused, JALR target, load/store address
br_taken  input  1  branch condition from ALU compare, valid in EXEC
dmem_req  output  1  data memory request, address = alu_result latched
dmem_we  output  4  byte write strobes; 0 = load
dmem_ready  input  1  data access complete this cycle
rf_we  output  1  register-file write, one-cycle pulse
wb_sel  output  2  0 ALU, 1 MEM, 2 PC+4
retire  output  1  one-cycle pulse per completed instruction
trap  output  1  sticky fault flag
trap_cause  output  2  0 illegal opcode, 1 misaligned, 2 timeout
state  output  3  current FSM state (debug)

Behaviour:
- Reset (async, reset_n low): state=IDLE, pc=RESET_PC, ir=0, all strobes/pulses 0, trap=0, trap_cause=0, timeout counter 0. Reset mid-request drops imem_req/dmem_req immediately (outputs decoded from state).
- States: IDLE(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5) HALT(6). IDLE→FETCH unconditionally one cycle after reset release.
- Handshake: req held high continuously until cycle with req&&ready; transfer completes on that edge. No request withdrawal.
- FETCH: imem_req=1. On imem_ready: ir<=imem_rdata, →DECODE.
- DECODE: opcode ir[6:0] checked against LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; else →HALT, cause 0.
- EXEC: BRANCH: pc<=br_taken ? pc+immB : pc+4, retire, →FETCH. LOAD/STORE: alignment check on alu_result[1:0] by funct3 (LH/LHU/SH need [0]=0, LW/SW need [1:0]=0) fail→HALT cause 1; else →MEM. Others →WB.
- MEM: dmem_req=1; dmem_we = SB 4'b0001<<a[1:0], SH 4'b0011<<{a[1],1'b0}, SW 4'b1111, loads 0. On dmem_ready: store → pc<=pc+4, retire, →FETCH; load →WB.
- WB: rf_we=1 (suppressed if rd=ir[11:7]=0), retire=1; wb_sel: LOAD 1, JAL/JALR 2, else 0. pc<= JAL pc+immJ; JALR {alu_result[31:1],1'b0}; else pc+4. →FETCH.
- Jump/branch target with target[1:0]≠0: →HALT cause 1, pc unchanged, no rf_we, no retire.
- Timeout: counter clears on entering FETCH/MEM; increments each cycle req&&!ready; reaching MEM_TIMEOUT →HALT cause 2, req drops next cycle.
- HALT: all reqs/pulses 0, trap=1, holds until reset. trap_cause written once on entry.
- All PC arithmetic modulo 2^32 (wrap at 0xFFFF_FFFC+4 → 0).
- Latency with zero-wait memory: branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles.

Decomposition:
- Package rv_pkg: opcode localparams, state encoding, trap cause codes, wb_sel codes, funct3 load/store codes.
- One sub-module rv_imm_gen: combinational B/J immediate extraction from ir, sign-extended to 32.

Test Plan:
- Reset: reset_n low 3 cycles then high → pc=0, imem_req=0 in IDLE, =1 next cycle; all pulses 0.
- ADDI x1,x0,5 (0x00500093), imem_ready immediate → retire on 4th cycle after FETCH, rf_we=1, wb_sel=0, pc=4.
- BEQ +8 at pc=0x10, br_taken=1 → pc=0x18 after EXEC; with br_taken=0 → pc=0x14; rf_we never asserted.
- SB with alu_result=0x103, dmem_ready after 2 wait cycles → dmem_we=4'b1000 held 3 cycles, retire, pc+4; LW alu_result=0x102 → trap=1, cause=1.
- Opcode 0x7F → HALT, trap_cause=0, no retire; stays halted 20 cycles; reset_n pulse clears to pc=RESET_PC.
- imem_ready held 0 → after MEM_TIMEOUT=16 wait cycles trap=1, cause=2, imem_req=0; async reset asserted mid-MEM wait drops dmem_req same cycle.
